// File: rtl/msu_pkg.sv
// Shared MSU1 definitions: sector width, file-select codes and the host
// arbiter state encoding.
package msu_pkg;

  localparam int SECTOR_W = 22;

  localparam logic FILE_AUDIO = 1'b0;
  localparam logic FILE_DATA  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_XFER     = 3'd3,
    ST_RELEASE  = 3'd4
  } arb_state_t;

  typedef struct packed {
    logic [SECTOR_W-1:0] sector;
    logic                file;
    logic                jump;
  } grant_t;

  // Ack/wr are routed to the winner from the first ack cycle to the end of the transfer.
  function automatic logic is_routing_state(arb_state_t s);
    return (s == ST_WAIT_ACK) || (s == ST_XFER);
  endfunction

endpackage

// File: rtl/msu_arb_pick.sv
// Combinational winner selector: urgent audio first, then the sole requester,
// then round-robin against the last-served file.
module msu_arb_pick
  import msu_pkg::*;
(
  input  logic a_pend,
  input  logic d_pend,
  input  logic a_urgent,
  input  logic last_served,
  output logic grant_valid,
  output logic grant_file
);

  always_comb begin
    grant_valid = a_pend | d_pend;
    grant_file  = FILE_AUDIO;
    if (a_pend && a_urgent) begin
      grant_file = FILE_AUDIO;
    end else if (a_pend && !d_pend) begin
      grant_file = FILE_AUDIO;
    end else if (d_pend && !a_pend) begin
      grant_file = FILE_DATA;
    end else if (a_pend && d_pend) begin
      grant_file = (last_served == FILE_DATA) ? FILE_AUDIO : FILE_DATA;
    end
  end

endmodule

// File: rtl/msu_ext_arbiter.sv
// Shares the single host sector interface between the MSU1 audio and data
// readers; ack/wr strobes are routed back to the current winner.
module msu_ext_arbiter
  import msu_pkg::*;
#(
  parameter int unsigned URGENT_LEVEL = 256,
  parameter logic [23:0] ACK_TIMEOUT  = 24'hFFFFFF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                a_req,
  input  logic                a_jump,
  input  logic [SECTOR_W-1:0] a_sector,
  input  logic [10:0]         a_fifo_usedw,
  input  logic                d_req,
  input  logic                d_jump,
  input  logic [SECTOR_W-1:0] d_sector,
  input  logic                ext_ack,
  input  logic                ext_wr,
  output logic                ext_req,
  output logic                ext_jump_sector,
  output logic [SECTOR_W-1:0] ext_sector,
  output logic                ext_file,
  output logic                a_ack,
  output logic                d_ack,
  output logic                a_wr,
  output logic                d_wr,
  output logic                timeout_err
);

  localparam logic [31:0] URGENT_W = 32'(URGENT_LEVEL);

  arb_state_t  state_q, state_d;
  grant_t      grant_q, grant_d;
  logic        ext_req_q, ext_req_d;
  logic        ext_jump_q, ext_jump_d;
  logic        timeout_q, timeout_d;
  logic        last_q, last_d;
  logic [23:0] cnt_q, cnt_d;

  logic a_pend, d_pend, a_urgent;
  logic pick_valid, pick_file;
  logic route_on;

  assign a_pend   = a_req | a_jump;
  assign d_pend   = d_req | d_jump;
  assign a_urgent = ({21'd0, a_fifo_usedw} < URGENT_W);

  msu_arb_pick u_pick (
    .a_pend      (a_pend),
    .d_pend      (d_pend),
    .a_urgent    (a_urgent),
    .last_served (last_q),
    .grant_valid (pick_valid),
    .grant_file  (pick_file)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ext_req_d  = ext_req_q;
    ext_jump_d = ext_jump_q;
    timeout_d  = 1'b0;
    last_d     = last_q;
    cnt_d      = cnt_q;

    case (state_q)
      ST_IDLE: begin
        // A still-high ext_ack means the host is finishing an old transfer.
        if (pick_valid && !ext_ack) begin
          grant_d.file   = pick_file;
          grant_d.sector = (pick_file == FILE_AUDIO) ? a_sector : d_sector;
          grant_d.jump   = (pick_file == FILE_AUDIO) ? a_jump : d_jump;
          state_d        = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        ext_req_d  = ~grant_q.jump;
        ext_jump_d = grant_q.jump;
        cnt_d      = 24'd0;
        state_d    = ST_WAIT_ACK;
      end

      ST_WAIT_ACK: begin
        if (ext_ack) begin
          ext_req_d  = 1'b0;
          ext_jump_d = 1'b0;
          state_d    = ST_XFER;
        end else begin
          cnt_d = (cnt_q == ACK_TIMEOUT) ? cnt_q : cnt_q + 24'd1;
          if (cnt_d == ACK_TIMEOUT) begin
            ext_req_d  = 1'b0;
            ext_jump_d = 1'b0;
            timeout_d  = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end

      ST_XFER: begin
        if (!ext_ack) begin
          last_d  = grant_q.file;
          state_d = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      ext_req_q  <= 1'b0;
      ext_jump_q <= 1'b0;
      timeout_q  <= 1'b0;
      last_q     <= FILE_DATA;
      cnt_q      <= 24'd0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ext_req_q  <= ext_req_d;
      ext_jump_q <= ext_jump_d;
      timeout_q  <= timeout_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
    end
  end

  // Strobe routing is purely combinational so host writes reach the FIFO with no added delay.
  assign route_on = ~reset & is_routing_state(state_q);

  assign a_ack = route_on & (grant_q.file == FILE_AUDIO) & ext_ack;
  assign d_ack = route_on & (grant_q.file == FILE_DATA)  & ext_ack;
  assign a_wr  = route_on & (grant_q.file == FILE_AUDIO) & ext_wr;
  assign d_wr  = route_on & (grant_q.file == FILE_DATA)  & ext_wr;

  assign ext_req         = ext_req_q;
  assign ext_jump_sector = ext_jump_q;
  assign ext_sector      = grant_q.sector;
  assign ext_file        = grant_q.file;
  assign timeout_err     = timeout_q;

endmodule

// File: tb/tb_msu_ext_arbiter.sv
// Directed bench for the MSU1 host arbiter: grants, round-robin, urgency,
// seeks, ack timeout, stale ack and reset mid-transfer.
module tb_msu_ext_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_jump, d_req, d_jump;
  logic [21:0] a_sector, d_sector;
  logic [10:0] a_fifo_usedw;
  logic        ext_ack, ext_wr;
  logic        ext_req, ext_jump_sector, ext_file;
  logic [21:0] ext_sector;
  logic        a_ack, d_ack, a_wr, d_wr, timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic        g_file;
  logic [21:0] g_sector;
  int          g_a, g_d;

  always #5 clk = ~clk;

  msu_ext_arbiter #(
    .URGENT_LEVEL (256),
    .ACK_TIMEOUT  (24'd16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .a_req           (a_req),
    .a_jump          (a_jump),
    .a_sector        (a_sector),
    .a_fifo_usedw    (a_fifo_usedw),
    .d_req           (d_req),
    .d_jump          (d_jump),
    .d_sector        (d_sector),
    .ext_ack         (ext_ack),
    .ext_wr          (ext_wr),
    .ext_req         (ext_req),
    .ext_jump_sector (ext_jump_sector),
    .ext_sector      (ext_sector),
    .ext_file        (ext_file),
    .a_ack           (a_ack),
    .d_ack           (d_ack),
    .a_wr            (a_wr),
    .d_wr            (d_wr),
    .timeout_err     (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({ext_req, ext_jump_sector, ext_file, timeout_err, a_ack, d_ack, a_wr, d_wr});
  endfunction

  // Requester/host model: wait for a grant, ack it, drop the acked request,
  // toggle ext_wr for 2*n_wr cycles (n_wr strobes), then end the transfer.
  task automatic serve(input int n_wr, output logic file, output logic [21:0] sector,
                       output int a_cnt, output int d_cnt);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (ext_req || ext_jump_sector) seen = 1'b1;
      else tick();
    end
    chk("grant_seen", 32'(seen), 32'd1);
    file   = ext_file;
    sector = ext_sector;
    ext_ack = 1'b1;
    #1;
    chk("ack_route", 32'({a_ack, d_ack}), file ? 32'd1 : 32'd2);
    if (a_ack) begin a_req = 1'b0; a_jump = 1'b0; end
    if (d_ack) begin d_req = 1'b0; d_jump = 1'b0; end
    tick();
    chk("req_drop", 32'({ext_req, ext_jump_sector}), 32'd0);
    a_cnt = 0;
    d_cnt = 0;
    for (int i = 0; i < 2 * n_wr; i++) begin
      ext_wr = (i % 2 == 0);
      #1;
      if (a_wr) a_cnt++;
      if (d_wr) d_cnt++;
      tick();
    end
    ext_wr  = 1'b0;
    ext_ack = 1'b0;
    tick();
    tick();
    $display("grant file=%0d sector=0x%0h a_wr=%0d d_wr=%0d", file, sector, a_cnt, d_cnt);
  endtask

  initial begin
    reset = 1'b1;
    a_req = 0; a_jump = 0; d_req = 0; d_jump = 0;
    a_sector = '0; d_sector = '0; a_fifo_usedw = 11'd900;
    ext_ack = 0; ext_wr = 0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset_outs", all_outs(), 32'd0);
    chk("reset_sector", 32'(ext_sector), 32'd0);

    // Single audio request, 256 host writes
    a_sector = 22'd5;
    a_req = 1'b1;
    tick();
    chk("issue_not_yet", 32'(ext_req), 32'd0);
    tick();
    chk("s1_req", 32'({ext_req, ext_jump_sector}), 32'd2);
    chk("s1_sector", 32'(ext_sector), 32'd5);
    chk("s1_file", 32'(ext_file), 32'd0);
    serve(256, g_file, g_sector, g_a, g_d);
    chk("s1_a_wr", 32'(g_a), 32'd256);
    chk("s1_d_wr", 32'(g_d), 32'd0);

    // Round-robin after a fresh reset, then urgency override
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    a_sector = 22'd10;
    d_sector = 22'd20;
    a_req = 1'b1;
    d_req = 1'b1;
    serve(2, g_file, g_sector, g_a, g_d);
    chk("rr1_file", 32'(g_file), 32'd0);
    chk("rr1_sector", 32'(g_sector), 32'd10);
    a_req = 1'b1;
    serve(2, g_file, g_sector, g_a, g_d);
    chk("rr2_file", 32'(g_file), 32'd1);
    chk("rr2_sector", 32'(g_sector), 32'd20);
    chk("rr2_wr", 32'({g_a[7:0], g_d[7:0]}), 32'h0002);
    d_req = 1'b1;
    serve(1, g_file, g_sector, g_a, g_d);
    chk("rr3_file", 32'(g_file), 32'd0);
    a_fifo_usedw = 11'd100;
    a_req = 1'b1;
    serve(1, g_file, g_sector, g_a, g_d);
    chk("urgent_file", 32'(g_file), 32'd0);
    a_fifo_usedw = 11'd900;
    serve(1, g_file, g_sector, g_a, g_d);
    chk("after_urgent_file", 32'(g_file), 32'd1);

    // Data seek with full-width sector; jump beats req
    d_sector = 22'h3FFFFF;
    d_jump = 1'b1;
    d_req = 1'b1;
    tick();
    tick();
    chk("jump_strobes", 32'({ext_req, ext_jump_sector}), 32'd1);
    chk("jump_file", 32'(ext_file), 32'd1);
    chk("jump_sector", 32'(ext_sector), 32'h3FFFFF);
    serve(1, g_file, g_sector, g_a, g_d);

    // Ack timeout: 16 cycles in WAIT_ACK
    a_sector = 22'd7;
    a_req = 1'b1;
    tick();
    tick();
    chk("to_req_up", 32'(ext_req), 32'd1);
    repeat (15) tick();
    chk("to_before", 32'({ext_req, timeout_err}), 32'd2);
    tick();
    chk("to_pulse", 32'({ext_req, timeout_err}), 32'd1);
    a_req = 1'b0;
    tick();
    chk("to_one_cycle", 32'({ext_req, timeout_err}), 32'd0);
    tick();
    tick();
    chk("to_idle", 32'({ext_req, ext_jump_sector}), 32'd0);
    // Last-served still data after the abandoned audio grant
    a_req = 1'b1;
    d_req = 1'b1;
    serve(1, g_file, g_sector, g_a, g_d);
    chk("to_last_a", 32'(g_file), 32'd0);
    serve(1, g_file, g_sector, g_a, g_d);
    chk("to_last_d", 32'(g_file), 32'd1);

    // Stale ext_ack in IDLE blocks a new request
    ext_ack = 1'b1;
    d_sector = 22'd33;
    d_req = 1'b1;
    repeat (4) tick();
    chk("stale_block", 32'({ext_req, ext_jump_sector}), 32'd0);
    ext_ack = 1'b0;
    tick();
    tick();
    chk("stale_release", 32'({ext_req, ext_file}), 32'd3);
    serve(1, g_file, g_sector, g_a, g_d);
    chk("stale_sector", 32'(g_sector), 32'd33);

    // Reset in the middle of an audio transfer
    a_sector = 22'd44;
    a_req = 1'b1;
    tick();
    tick();
    ext_ack = 1'b1;
    #1;
    a_req = 1'b0;
    tick();
    ext_wr = 1'b1;
    #1;
    chk("mid_a_wr", 32'({a_wr, d_wr}), 32'd2);
    reset = 1'b1;
    #1;
    chk("rst_gate", 32'({a_ack, d_ack, a_wr, d_wr}), 32'd0);
    tick();
    chk("rst_outs_mid", all_outs(), 32'd0);
    chk("rst_sector_mid", 32'(ext_sector), 32'd0);
    for (int i = 0; i < 4; i++) begin
      ext_wr = (i % 2 == 0);
      #1;
      chk("rst_wr_held", 32'({a_wr, d_wr}), 32'd0);
      tick();
    end
    reset = 1'b0;
    ext_ack = 1'b0;
    ext_wr = 1'b0;
    tick();
    chk("post_rst_outs", all_outs(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/msu_ext_arbiter.md
MSU_EXT_ARBITER -- requirements
Module: msu_ext_arbiter

Interface
REQ-001 SHALL use parameter URGENT_LEVEL, default 256: audio FIFO fill (dwords) below which audio has absolute priority.
REQ-002 SHALL use parameter ACK_TIMEOUT, default 24'hFFFFFF: cycles to wait for ext_ack before a grant is abandoned.
REQ-003 SHALL have ports, in order:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high.
- a_req  in  1  audio next-sector request; level, held until a_ack rises.
- a_jump  in  1  audio seek request; level, held until a_ack rises.
- a_sector  in  22  audio sector number.
- a_fifo_usedw  in  11  audio FIFO fill level.
- d_req  in  1  data-track next-sector request; level.
- d_jump  in  1  data-track seek request; level.
- d_sector  in  22  data sector number.
- ext_ack  in  1  host busy/ack; high for the whole sector transfer.
- ext_wr  in  1  host dword write strobe.
- ext_req  out  1  shared host next-sector request.
- ext_jump_sector  out  1  shared host seek request.
- ext_sector  out  22  shared sector number.
- ext_file  out  1  file select: 0 = audio, 1 = data.
- a_ack, d_ack  out  1 each  per-requester copy of ext_ack.
- a_wr, d_wr  out  1 each  per-requester copy of ext_wr.
- timeout_err  out  1  one-cycle pulse on abandoned grant.

Function
REQ-004 SHALL implement states IDLE, ISSUE, WAIT_ACK, XFER, RELEASE.
REQ-005 IDLE: if any request (req or jump) is pending, SHALL select a winner, latch its sector, file and jump flag, and go to ISSUE on the next cycle.
REQ-006 Winner selection SHALL be:
- Audio wins if audio is pending and a_fifo_usedw < URGENT_LEVEL.
- Otherwise, with only one requester pending, that requester wins.
- Otherwise, with both pending, the requester not served last wins (round-robin).
REQ-007 ISSUE: SHALL drive ext_sector and ext_file from the latched values, and assert ext_jump_sector if the latched jump is set, else ext_req. SHALL go to WAIT_ACK the same cycle and clear the timeout counter.
REQ-008 WAIT_ACK: SHALL hold ext_req/ext_jump_sector until ext_ack is sampled high, then deassert both next cycle and go to XFER.
REQ-009 XFER: ack and wr routing SHALL be combinational from ext_ack/ext_wr, so routed strobes have zero added latency.
- Granted requester: x_ack = ext_ack, x_wr = ext_wr.
- Non-granted requester: x_ack = 0, x_wr = 0.
REQ-010 XFER: on ext_ack low, SHALL go to RELEASE and record the winner as last-served.
REQ-011 RELEASE: SHALL stay one cycle, then return to IDLE. This gives the requester one cycle to drop req before re-arbitration.
REQ-012 ext_sector and ext_file SHALL stay stable from ISSUE until RELEASE exits.
REQ-013 Jump SHALL take precedence over req when both are asserted by the same requester.
REQ-014 Requests that change while not granted SHALL NOT affect the current grant.
REQ-015 Timeout counter (24 bits) SHALL:
- Increment every cycle in WAIT_ACK.
- Saturate at ACK_TIMEOUT; when it reaches ACK_TIMEOUT, deassert the request, pulse timeout_err for one cycle, and go to IDLE with last-served unchanged.
REQ-016 If ext_ack is high in IDLE (stale transfer), SHALL NOT issue a new request until ext_ack is low.
REQ-017 Simultaneous audio-urgent and data requests SHALL always grant audio, regardless of round-robin state.

Reset
REQ-018 On reset, SHALL set state IDLE and last-served = data, so audio wins the first tie.
REQ-019 On reset, SHALL set to 0: ext_req, ext_jump_sector, ext_sector, ext_file, timeout_err, and the timeout counter.
REQ-020 Reset mid-transfer SHALL take effect in one cycle, and SHALL force a_ack, d_ack, a_wr and d_wr to 0 while reset is high.

Structure
REQ-021 State encoding, FILE_AUDIO/FILE_DATA constants and the 22-bit sector width SHALL live in the shared MSU package used by the other MSU1 blocks.
REQ-022 SHALL be one module, with one natural sub-module msu_arb_pick: a combinational winner selector taking pending flags, urgency and last-served.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Audio a_req with sector 5, no data request: ext_req high with ext_sector 5 and ext_file 0; ext_ack high for 256 ext_wr → 256 a_wr, 0 d_wr.
- a_req and d_req raised in the same cycle, usedw 900, after reset: audio granted first, data second, then ties alternate.
- d_req pending and audio served last, a_req with usedw 100: audio granted despite round-robin.
- d_jump with d_sector 0x3FFFFF: ext_jump_sector high, ext_req low, ext_file 1, full 22-bit sector passed.
- ACK_TIMEOUT = 16, no ext_ack: timeout_err pulses 16 cycles after ISSUE, state IDLE, request dropped.
- reset asserted mid-XFER with ext_wr toggling: next cycle all outputs 0; a_wr/d_wr stay 0.
